axil_req_arbiter: RTL and testbench
===================================

Name: axil_req_arbiter

Overview:
- Round-robin arbiter and AXI4-Lite master sequencer that shares the AXI4-Lite register-memory slave between NUM_REQ internal requesters.
- Each requester issues single-beat read/write commands on a simple valid/ready port and receives a one-cycle response pulse.
- The block serialises them into exactly one outstanding AXI4-Lite transaction at a time.
- Sits between the configuration clients (CPU bridge, DMA descriptor fetch, debug port) and the slave's SAXI port.

Parameters:
- NUM_REQ, 4, number of requesters (>=2).
- DATA_WIDTH, 32, data width in bits (fixed at 32; WSTRB is 4 bits).
- ADDR_WIDTH, 32, byte-address width.

Ports:
- ACLK  in  1  clock. One clock; ARESET asynchronous, active-high.
- ARESET  in  1  reset. Asynchronous, active-high.
- req_valid  in  NUM_REQ  per-requester command valid.
- req_write  in  NUM_REQ  1=write, 0=read.
- req_addr  in  NUM_REQ*ADDR_WIDTH  packed byte addresses, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_wdata  in  NUM_REQ*DATA_WIDTH  packed write data.
- req_wstrb  in  NUM_REQ*4  packed byte strobes.
- req_ready  out  NUM_REQ  one-hot, one-cycle command-accept pulse.
- rsp_valid  out  NUM_REQ  one-hot, one-cycle completion pulse.
- rsp_rdata  out  DATA_WIDTH  read data; valid with rsp_valid.
- rsp_resp  out  2  AXI response (RRESP/BRESP); valid with rsp_valid.
- M_AWADDR/M_AWVALID/M_AWREADY  out/out/in  ADDR_WIDTH/1/1  write-address channel.
- M_WDATA/M_WSTRB/M_WVALID/M_WREADY  out/out/out/in  DATA_WIDTH/4/1/1  write-data channel.
- M_BRESP/M_BVALID/M_BREADY  in/in/out  2/1/1  write-response channel.
- M_ARADDR/M_ARVALID/M_ARREADY  out/out/in  ADDR_WIDTH/1/1  read-address channel.
- M_RDATA/M_RRESP/M_RVALID/M_RREADY  in/in/in/out  DATA_WIDTH/2/1/1  read-data channel.

Behaviour:
- Reset values: all outputs 0; state IDLE; rr_ptr 0; grant index 0. Reset mid-transaction drops all VALID/READY outputs immediately; no response is generated for the aborted command.
- State machine: IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA.
- IDLE:
  - If any req_valid, grant the first set bit searching from rr_ptr upward with wrap modulo NUM_REQ.
  - Pulse req_ready[g] combinationally in that cycle.
  - Latch addr/wdata/wstrb/write of requester g.
  - Next state is WR_ADDR_DATA if write, else RD_ADDR.
- Requester protocol: requesters hold valid and payload stable until req_ready. A requester may reassert req_valid in the cycle after its rsp_valid.
- WR_ADDR_DATA:
  - M_AWVALID and M_WVALID assert together from the first cycle.
  - Each drops independently after its own handshake; hold flags track aw_done and w_done.
  - Once both have handshaken (the same cycle or different cycles), go to WR_RESP.
- WR_RESP: M_BREADY=1. On a BVALID&BREADY handshake, register rsp_resp=M_BRESP and rsp_rdata=0, pulse rsp_valid[g] the next cycle, and go to IDLE.
- RD_ADDR: M_ARVALID=1 until the ARREADY handshake, then RD_DATA.
- RD_DATA: M_RREADY=1. On a handshake, register rsp_rdata=M_RDATA and rsp_resp=M_RRESP, pulse rsp_valid[g] the next cycle, and go to IDLE.
- Round-robin pointer: on completion, rr_ptr <= (g+1) mod NUM_REQ. No pointer update while idle with no requests.
- Latency against a zero-wait slave:
  - req_ready at cycle 0; AW/W or AR handshake at cycle 1.
  - BVALID/RVALID at cycle 2; rsp_valid at cycle 3.
  - Next grant is possible at cycle 3, the same cycle as rsp_valid, since the FSM is in IDLE.
- Payload stability: M_* payloads are driven from latched registers and stay stable while VALID is high; VALID is never withdrawn before its handshake.
- Error responses: SLVERR/DECERR pass through unchanged; no retry.
- Single requester: with only one req_valid, that requester is granted back-to-back regardless of rr_ptr.

Decomposition:
- Package axil_pkg holds:
  - resp_t with OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11.
  - arb_state_t enum.
- Sub-module rr_arbiter (parameter N): inputs req vector and ptr; outputs one-hot grant and grant index. Purely combinational; reused elsewhere.

Test Plan:
- Single write: requester 1 writes addr 0x08, data 0xDEADBEEF, strb 4'hF -> one AW/W handshake with AWADDR=0x08; rsp_valid[1] at cycle 3 with rsp_resp=00. A following read of 0x08 returns rsp_rdata=0xDEADBEEF.
- Contention: all 4 requesters assert reads to 0x00/0x04/0x08/0x0C in the same cycle -> grants in order 0,1,2,3; a second simultaneous burst starts at 0 again. No requester is starved.
- Back-pressure: slave holds AWREADY low 3 cycles while WREADY is accepted at cycle 1 -> WVALID drops after cycle 1, AWVALID held with a stable address until accepted, then exactly one B handshake.
- Out-of-range: requester 2 reads addr 0x200 with MEM_DEPTH=32 -> rsp_resp=2'b10, rsp_rdata=0.
- Partial write: strb 4'b0011 with data 0x12345678 over 0xFFFFFFFF -> readback is 0xFFFF5678.
- Reset mid-op: ARESET asserted while in WR_RESP -> M_BREADY and all VALIDs go 0 asynchronously, no rsp_valid. After release the next grant starts from requester 0.

Source files
------------

// File: rtl/axil_pkg.sv
// Shared types for the AXI4-Lite request arbiter: response codes and sequencer states.
package axil_pkg;

    localparam int unsigned STRB_WIDTH = 4;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } resp_t;

    typedef enum logic [2:0] {
        IDLE,
        WR_ADDR_DATA,
        WR_RESP,
        RD_ADDR,
        RD_DATA
    } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or above i_ptr, wrapping modulo N.
module rr_arbiter #(
    parameter int unsigned N  = 4,
    parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [N-1:0]  o_grant,
    output logic [IW-1:0] o_idx
);

    logic [IW-1:0] w_pos;
    logic          w_found;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        w_pos   = '0;
        w_found = 1'b0;
        for (int unsigned k = 0; k < N; k++) begin
            w_pos = IW'((32'(i_ptr) + k) % N);
            if (!w_found && i_req[w_pos]) begin
                o_grant[w_pos] = 1'b1;
                o_idx          = w_pos;
                w_found        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/axil_req_arbiter.sv
// Shares one AXI4-Lite slave between NUM_REQ requesters, one outstanding transaction at a time.
module axil_req_arbiter
    import axil_pkg::*;
#(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                             ACLK,
    input  logic                             ARESET,
    input  logic [NUM_REQ-1:0]               req_valid,
    input  logic [NUM_REQ-1:0]               req_write,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata,
    input  logic [NUM_REQ*STRB_WIDTH-1:0]    req_wstrb,
    output logic [NUM_REQ-1:0]               req_ready,
    output logic [NUM_REQ-1:0]               rsp_valid,
    output logic [DATA_WIDTH-1:0]            rsp_rdata,
    output logic [1:0]                       rsp_resp,
    output logic [ADDR_WIDTH-1:0]            M_AWADDR,
    output logic                             M_AWVALID,
    input  logic                             M_AWREADY,
    output logic [DATA_WIDTH-1:0]            M_WDATA,
    output logic [STRB_WIDTH-1:0]            M_WSTRB,
    output logic                             M_WVALID,
    input  logic                             M_WREADY,
    input  logic [1:0]                       M_BRESP,
    input  logic                             M_BVALID,
    output logic                             M_BREADY,
    output logic [ADDR_WIDTH-1:0]            M_ARADDR,
    output logic                             M_ARVALID,
    input  logic                             M_ARREADY,
    input  logic [DATA_WIDTH-1:0]            M_RDATA,
    input  logic [1:0]                       M_RRESP,
    input  logic                             M_RVALID,
    output logic                             M_RREADY
);

    localparam int unsigned IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    arb_state_t              r_state;
    arb_state_t              w_next;
    logic [IW-1:0]           r_rr_ptr;
    logic [IW-1:0]           r_gnt_idx;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic [STRB_WIDTH-1:0]   r_wstrb;
    logic                    r_aw_done;
    logic                    r_w_done;
    logic [NUM_REQ-1:0]      r_rsp_valid;
    logic [DATA_WIDTH-1:0]   r_rsp_rdata;
    logic [1:0]              r_rsp_resp;
    logic [NUM_REQ-1:0]      w_grant;
    logic [IW-1:0]           w_gidx;
    logic                    w_accept;

    rr_arbiter #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_rr (
        .i_req   (req_valid),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_grant),
        .o_idx   (w_gidx)
    );

    assign M_AWADDR  = r_addr;
    assign M_ARADDR  = r_addr;
    assign M_WDATA   = r_wdata;
    assign M_WSTRB   = r_wstrb;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_resp  = r_rsp_resp;

    always_comb begin
        w_next    = r_state;
        w_accept  = 1'b0;
        req_ready = '0;
        M_AWVALID = 1'b0;
        M_WVALID  = 1'b0;
        M_BREADY  = 1'b0;
        M_ARVALID = 1'b0;
        M_RREADY  = 1'b0;
        case (r_state)
            IDLE: begin
                // Gate with reset so no accept pulse escapes while the registers are held.
                if (|req_valid && !ARESET) begin
                    w_accept  = 1'b1;
                    req_ready = w_grant;
                    w_next    = req_write[w_gidx] ? WR_ADDR_DATA : RD_ADDR;
                end
            end
            WR_ADDR_DATA: begin
                M_AWVALID = !r_aw_done;
                M_WVALID  = !r_w_done;
                if ((r_aw_done || M_AWREADY) && (r_w_done || M_WREADY))
                    w_next = WR_RESP;
            end
            WR_RESP: begin
                M_BREADY = 1'b1;
                if (M_BVALID)
                    w_next = IDLE;
            end
            RD_ADDR: begin
                M_ARVALID = 1'b1;
                if (M_ARREADY)
                    w_next = RD_DATA;
            end
            RD_DATA: begin
                M_RREADY = 1'b1;
                if (M_RVALID)
                    w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_state     <= IDLE;
            r_rr_ptr    <= '0;
            r_gnt_idx   <= '0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_wstrb     <= '0;
            r_aw_done   <= 1'b0;
            r_w_done    <= 1'b0;
            r_rsp_valid <= '0;
            r_rsp_rdata <= '0;
            r_rsp_resp  <= '0;
        end else begin
            r_state     <= w_next;
            r_rsp_valid <= '0;
            if (w_accept) begin
                r_gnt_idx <= w_gidx;
                r_addr    <= req_addr[w_gidx*ADDR_WIDTH +: ADDR_WIDTH];
                r_wdata   <= req_wdata[w_gidx*DATA_WIDTH +: DATA_WIDTH];
                r_wstrb   <= req_wstrb[w_gidx*STRB_WIDTH +: STRB_WIDTH];
                r_aw_done <= 1'b0;
                r_w_done  <= 1'b0;
            end
            if (M_AWVALID && M_AWREADY)
                r_aw_done <= 1'b1;
            if (M_WVALID && M_WREADY)
                r_w_done <= 1'b1;
            if ((M_BREADY && M_BVALID) || (M_RREADY && M_RVALID)) begin
                r_rsp_valid[r_gnt_idx] <= 1'b1;
                r_rsp_rdata            <= M_RREADY ? M_RDATA : '0;
                r_rsp_resp             <= M_RREADY ? M_RRESP : M_BRESP;
                r_rr_ptr               <= (r_gnt_idx == IW'(NUM_REQ - 1)) ? '0 : r_gnt_idx + IW'(1);
            end
        end
    end

endmodule

// File: tb/tb_axil_req_arbiter.sv
// Directed bench for axil_req_arbiter against a 32-word AXI4-Lite register-memory slave.
module tb_axil_req_arbiter;

    logic          ACLK = 1'b0;
    logic          ARESET = 1'b0;
    logic [3:0]    req_valid, req_write, req_ready, rsp_valid;
    logic [127:0]  req_addr, req_wdata;
    logic [15:0]   req_wstrb;
    logic [31:0]   rsp_rdata;
    logic [1:0]    rsp_resp;
    logic [31:0]   M_AWADDR, M_WDATA, M_ARADDR, M_RDATA;
    logic [3:0]    M_WSTRB;
    logic          M_AWVALID, M_AWREADY, M_WVALID, M_WREADY, M_BVALID, M_BREADY;
    logic          M_ARVALID, M_ARREADY, M_RVALID, M_RREADY;
    logic [1:0]    M_BRESP, M_RRESP;

    int n_run = 0;
    int n_fail = 0;

    always #5 ACLK = ~ACLK;

    axil_req_arbiter #(.NUM_REQ(4), .DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_wstrb(req_wstrb), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
        .M_AWADDR(M_AWADDR), .M_AWVALID(M_AWVALID), .M_AWREADY(M_AWREADY),
        .M_WDATA(M_WDATA), .M_WSTRB(M_WSTRB), .M_WVALID(M_WVALID), .M_WREADY(M_WREADY),
        .M_BRESP(M_BRESP), .M_BVALID(M_BVALID), .M_BREADY(M_BREADY),
        .M_ARADDR(M_ARADDR), .M_ARVALID(M_ARVALID), .M_ARREADY(M_ARREADY),
        .M_RDATA(M_RDATA), .M_RRESP(M_RRESP), .M_RVALID(M_RVALID), .M_RREADY(M_RREADY)
    );

    // Slave: 32 words at byte addresses 0x00-0x7F, SLVERR beyond.
    logic [31:0] mem [32];
    logic        have_aw, have_w;
    logic [31:0] s_awaddr, s_wdata, sa, sd;
    logic [3:0]  s_wstrb, ss;

    always @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            M_BVALID <= 1'b0; M_RVALID <= 1'b0; M_BRESP <= 2'b00;
            M_RDATA  <= '0;   M_RRESP  <= 2'b00;
            have_aw  <= 1'b0; have_w   <= 1'b0;
            s_awaddr <= '0;   s_wdata  <= '0;   s_wstrb <= '0;
            for (int i = 0; i < 32; i++) mem[i] <= '0;
        end else begin
            if (M_BVALID && M_BREADY) M_BVALID <= 1'b0;
            if (M_RVALID && M_RREADY) M_RVALID <= 1'b0;
            if (M_AWVALID && M_AWREADY) begin s_awaddr <= M_AWADDR; have_aw <= 1'b1; end
            if (M_WVALID && M_WREADY) begin s_wdata <= M_WDATA; s_wstrb <= M_WSTRB; have_w <= 1'b1; end
            sa = (M_AWVALID && M_AWREADY) ? M_AWADDR : s_awaddr;
            sd = (M_WVALID && M_WREADY) ? M_WDATA : s_wdata;
            ss = (M_WVALID && M_WREADY) ? M_WSTRB : s_wstrb;
            if ((have_aw || (M_AWVALID && M_AWREADY)) && (have_w || (M_WVALID && M_WREADY))) begin
                if (sa < 32'd128) begin
                    for (int b = 0; b < 4; b++)
                        if (ss[b]) mem[sa[6:2]][8*b +: 8] <= sd[8*b +: 8];
                    M_BRESP <= 2'b00;
                end else begin
                    M_BRESP <= 2'b10;
                end
                M_BVALID <= 1'b1; have_aw <= 1'b0; have_w <= 1'b0;
            end
            if (M_ARVALID && M_ARREADY) begin
                M_RVALID <= 1'b1;
                if (M_ARADDR < 32'd128) begin M_RDATA <= mem[M_ARADDR[6:2]]; M_RRESP <= 2'b00; end
                else begin M_RDATA <= '0; M_RRESP <= 2'b10; end
            end
        end
    end

    // Handshake counters and AW hold-stability watcher.
    int aw_cnt = 0, w_cnt = 0, b_cnt = 0, rsp_cnt = 0, aw_viol = 0;
    logic [31:0] last_awaddr = '0, p_awa = '0;
    logic p_awv = 1'b0, p_awhs = 1'b0;

    always @(negedge ACLK) begin
        if (!ARESET && p_awv && !p_awhs && (!M_AWVALID || M_AWADDR !== p_awa)) aw_viol++;
        p_awv  = M_AWVALID;
        p_awhs = M_AWVALID && M_AWREADY;
        p_awa  = M_AWADDR;
        if (M_AWVALID && M_AWREADY) begin aw_cnt++; last_awaddr = M_AWADDR; end
        if (M_WVALID && M_WREADY) w_cnt++;
        if (M_BVALID && M_BREADY) b_cnt++;
        if (|rsp_valid) rsp_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge ACLK); #1;
    endtask

    task automatic do_req(input int id, input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] strb, output logic [31:0] rdata, output logic [1:0] resp,
                          output int gwait, output int lat);
        rdata = '0; resp = '0; lat = -1; gwait = 0;
        req_valid[id] = 1'b1; req_write[id] = wr;
        req_addr[id*32 +: 32] = addr; req_wdata[id*32 +: 32] = wdata; req_wstrb[id*4 +: 4] = strb;
        #1;
        while (!req_ready[id] && gwait < 20) begin @(negedge ACLK); #1; gwait++; end
        @(posedge ACLK); #1;
        req_valid[id] = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge ACLK);
            if (rsp_valid[id]) begin lat = n; rdata = rsp_rdata; resp = rsp_resp; break; end
        end
    endtask

    int g_order[$];
    int g_cyc[$];
    int g_nrsp;

    task automatic run_burst(input logic [3:0] mask);
        logic [3:0] pending;
        g_order.delete(); g_cyc.delete(); g_nrsp = 0; pending = mask;
        for (int i = 0; i < 4; i++) begin
            req_valid[i] = mask[i]; req_write[i] = 1'b0; req_addr[i*32 +: 32] = 32'(i * 4);
        end
        for (int c = 0; c < 100; c++) begin
            #1;
            if (|rsp_valid) g_nrsp++;
            if (pending == 4'b0 && g_nrsp == $countones(mask)) break;
            if (req_ready != 4'b0) begin
                for (int i = 0; i < 4; i++)
                    if (req_ready[i]) begin g_order.push_back(i); g_cyc.push_back(c); pending[i] = 1'b0; end
                @(posedge ACLK); #1;
                req_valid = req_valid & pending;
            end
            @(negedge ACLK);
        end
        req_valid = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed simulation still running, required finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic [1:0]  rs;
        int gw, lat, a0, w0, b0, r0;

        req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
        M_AWREADY = 1'b1; M_WREADY = 1'b1; M_ARREADY = 1'b1;
        #2 ARESET = 1'b1;
        step(); step();
        chk("reset_valids", {28'd0, M_AWVALID, M_WVALID, M_BREADY, M_ARVALID}, 32'd0);
        chk("reset_rready_rsp", {23'd0, M_RREADY, req_ready, rsp_valid}, 32'd0);
        chk("reset_rsp_data", {rsp_rdata[29:0], rsp_resp}, 32'd0);
        chk("reset_awaddr", M_AWADDR, 32'd0);
        ARESET = 1'b0;
        step();

        // Contention: all four read together, twice.
        for (int burst = 0; burst < 2; burst++) begin
            @(negedge ACLK);
            run_burst(4'hF);
            chk("cont_count", g_order.size(), 4);
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("cont%0d_order%0d", burst, i), g_order[i], i);
                chk($sformatf("cont%0d_cyc%0d", burst, i), g_cyc[i], 3 * i);
            end
            chk("cont_nrsp", g_nrsp, 4);
        end

        // Single write then read-back by requester 1.
        @(negedge ACLK);
        a0 = aw_cnt; w0 = w_cnt; b0 = b_cnt;
        do_req(1, 1'b1, 32'h08, 32'hDEADBEEF, 4'hF, rd, rs, gw, lat);
        chk("wr_grant_wait", gw, 0);
        chk("wr_latency", lat, 3);
        chk("wr_resp", rs, 2'b00);
        chk("wr_rdata_zero", rd, 32'd0);
        chk("wr_aw_cnt", aw_cnt - a0, 1);
        chk("wr_w_cnt", w_cnt - w0, 1);
        chk("wr_b_cnt", b_cnt - b0, 1);
        chk("wr_awaddr", last_awaddr, 32'h08);
        @(negedge ACLK);
        do_req(1, 1'b0, 32'h08, 32'h0, 4'h0, rd, rs, gw, lat);
        chk("rd_latency", lat, 3);
        chk("rd_data", rd, 32'hDEADBEEF);
        chk("rd_resp", rs, 2'b00);

        // Partial write.
        @(negedge ACLK);
        do_req(1, 1'b1, 32'h20, 32'hFFFFFFFF, 4'hF, rd, rs, gw, lat);
        @(negedge ACLK);
        do_req(1, 1'b1, 32'h20, 32'h12345678, 4'b0011, rd, rs, gw, lat);
        chk("pw_grant_wait", gw, 0);
        @(negedge ACLK);
        do_req(1, 1'b0, 32'h20, 32'h0, 4'h0, rd, rs, gw, lat);
        chk("pw_readback", rd, 32'hFFFF5678);

        // Back-pressure on AW while W is accepted at once.
        @(negedge ACLK);
        a0 = aw_cnt; w0 = w_cnt; b0 = b_cnt;
        M_AWREADY = 1'b0;
        req_valid[0] = 1'b1; req_write[0] = 1'b1; req_addr[31:0] = 32'h10;
        req_wdata[31:0] = 32'hA5A5A5A5; req_wstrb[3:0] = 4'hF;
        #1 chk("bp_ready", req_ready, 4'b0001);
        @(posedge ACLK); #1 req_valid[0] = 1'b0;
        step(); chk("bp_c1_valids", {M_AWVALID, M_WVALID}, 2'b11);
        step(); chk("bp_c2_valids", {M_AWVALID, M_WVALID}, 2'b10);
        chk("bp_c2_awaddr", M_AWADDR, 32'h10);
        step(); chk("bp_c3_valids", {M_AWVALID, M_WVALID}, 2'b10);
        @(posedge ACLK); #1 M_AWREADY = 1'b1;
        step(); chk("bp_c4_awvalid", M_AWVALID, 1);
        chk("bp_c4_aw_cnt", aw_cnt - a0, 1);
        step(); chk("bp_c5_bready", {M_AWVALID, M_BREADY}, 2'b01);
        step(); chk("bp_c6_rsp", rsp_valid, 4'b0001);
        chk("bp_w_cnt", w_cnt - w0, 1);
        chk("bp_b_cnt", b_cnt - b0, 1);
        chk("bp_aw_stable", aw_viol, 0);
        @(negedge ACLK);
        do_req(0, 1'b0, 32'h10, 32'h0, 4'h0, rd, rs, gw, lat);
        chk("bp_readback", rd, 32'hA5A5A5A5);

        // Out-of-range read.
        @(negedge ACLK);
        do_req(2, 1'b0, 32'h200, 32'h0, 4'h0, rd, rs, gw, lat);
        chk("oor_latency", lat, 3);
        chk("oor_resp", rs, 2'b10);
        chk("oor_rdata", rd, 32'd0);

        // Reset while waiting for B.
        @(negedge ACLK);
        req_valid[3] = 1'b1; req_write[3] = 1'b1; req_addr[127:96] = 32'h30;
        req_wdata[127:96] = 32'h55AA55AA; req_wstrb[15:12] = 4'hF;
        #1 chk("rst_op_ready", req_ready, 4'b1000);
        @(posedge ACLK); #1 req_valid[3] = 1'b0;
        step();
        step(); chk("rst_op_bready", M_BREADY, 1);
        ARESET = 1'b1;
        #1;
        chk("rst_op_outs", {26'd0, M_AWVALID, M_WVALID, M_BREADY, M_ARVALID, M_RREADY, |rsp_valid}, 32'd0);
        r0 = rsp_cnt;
        step(); step();
        ARESET = 1'b0;
        step(); step(); step();
        chk("rst_op_no_rsp", rsp_cnt - r0, 0);
        run_burst(4'b1010);
        chk("rst_post_count", g_order.size(), 2);
        chk("rst_post_first", g_order[0], 1);
        chk("rst_post_second", g_order[1], 3);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
